pi_sigma_stage: RTL and testbench

- Round stage directly downstream of the theta diffusion layer in the iterative round datapath.
- pi: transposes the 4x4 byte state matrix. sigma: XORs the transposed state with the round key for the current round.
- Holds the round-key RAM and the per-block round counter.
- Output passes through a 2-entry buffer with valid/ready handshakes on both sides. Feeds the next round's gamma stage, or the ciphertext output.

---
 rtl/cipher_pkg.sv | 35 +++
 rtl/buf2_fifo.sv | 77 +++++++
 rtl/pi_sigma_stage.sv | 121 ++++++++++++
 tb/tb_pi_sigma_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cipher_pkg
//  Description : Shared constants, types and the pi (byte transpose) helper
//                for the iterative round datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package cipher_pkg;

    localparam int STATE_W    = 128;
    localparam int BYTE_W     = 8;
    localparam int NUM_ROUNDS = 8;
    localparam int KEY_SLOTS  = NUM_ROUNDS + 1;
    localparam int ROUND_W    = 4;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [ROUND_W-1:0] round_t;

    // State is a 4x4 byte matrix, row-major, byte (0,0) in the top bits.
    // Output byte (i,j) takes input byte (j,i). The transpose is its own
    // inverse, so the decryption path calls this same function.
    function automatic state_t pi_transpose(input state_t s);
        state_t t;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                t[STATE_W-1-BYTE_W*(4*i+j) -: BYTE_W] =
                    s[STATE_W-1-BYTE_W*(4*j+i) -: BYTE_W];
            end
        end
        return t;
    endfunction

endpackage : cipher_pkg
`default_nettype wire

// File: rtl/buf2_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : buf2_fifo
//  Description : Two-entry valid/ready FIFO with a registered upstream ready.
//                An entry written at edge N is visible on the output side
//                right after edge N, so an empty FIFO adds one cycle.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_valid/o_ready/i_data  - upstream handshake and payload
//                o_valid/i_ready/o_data  - downstream handshake and payload
//  Revision    : 1.0 - initial release
// ============================================================================
module buf2_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;

    assign w_push = i_valid && r_ready;
    assign w_pop  = (r_count != 2'd0) && i_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            // Held low through reset; rises on the first edge afterwards.
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
            // Ready is a pure register of the next occupancy, so there is
            // no combinational path from i_ready to o_ready.
            r_ready <= (w_count_next != 2'd2);
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];

endmodule : buf2_fifo
`default_nettype wire

// File: rtl/pi_sigma_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pi_sigma_stage
//  Description : Round stage after theta. pi transposes the 4x4 byte state,
//                sigma XORs it with the round key of the current round.
//                Holds the round-key slots and the per-block round counter;
//                results leave through a two-entry valid/ready buffer.
//  Ports       : clk, rst                 - clock, async active-high reset
//                i_key_we/addr/wdata      - round-key slot write
//                i_in_valid/o_in_ready    - input handshake
//                i_in_data, i_in_first    - diffused state, new-block flag
//                o_out_valid/i_out_ready  - output handshake
//                o_out_data/round/last    - result, its round, final round
//                o_seq_err                - sticky round-sequencing error
//  Revision    : 1.0 - initial release
// ============================================================================
module pi_sigma_stage #(
    parameter int NUM_ROUNDS = 8,
    parameter int STATE_W    = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_key_we,
    input  logic [3:0]         i_key_addr,
    input  logic [STATE_W-1:0] i_key_wdata,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [STATE_W-1:0] i_in_data,
    input  logic               i_in_first,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [STATE_W-1:0] o_out_data,
    output logic [3:0]         o_out_round,
    output logic               o_out_last,
    output logic               o_seq_err
);

    import cipher_pkg::*;

    localparam int     SLOTS      = NUM_ROUNDS + 1;
    localparam int     BUF_W      = STATE_W + ROUND_W;
    localparam round_t LAST_ROUND = round_t'(NUM_ROUNDS);

    // Slot 0 is the whitening key; it is stored here but only read upstream.
    logic [STATE_W-1:0] r_key [SLOTS];
    round_t             r_round;
    logic               r_seq_err;

    logic               w_in_ready;
    logic               w_accept;
    round_t             w_k;
    logic               w_seq_viol;
    logic [STATE_W-1:0] w_sigma;
    logic [BUF_W-1:0]   w_buf_out;

    assign w_accept = i_in_valid && w_in_ready;

    // Round index for the beat on the input. A continuation beat is only
    // legal mid-block; after the final round (or before any block) it is
    // restarted at round 1 and flagged.
    always_comb begin
        w_k        = round_t'(1);
        w_seq_viol = 1'b0;
        if (i_in_first) begin
            w_k = round_t'(1);
        end else if ((r_round != '0) && (r_round < LAST_ROUND)) begin
            w_k = r_round + round_t'(1);
        end else begin
            w_seq_viol = 1'b1;
        end
    end

    // Key is read from the register as it stood before this edge, so a
    // same-cycle write to the same slot only affects later beats.
    assign w_sigma = pi_transpose(i_in_data) ^ r_key[w_k];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_key[i] <= '0;
            end
        end else if (i_key_we && (i_key_addr <= LAST_ROUND)) begin
            r_key[i_key_addr] <= i_key_wdata;
        end
    end

    // Counter and error only move on an accepted beat; a full buffer
    // leaves both untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round   <= '0;
            r_seq_err <= 1'b0;
        end else if (w_accept) begin
            r_round <= w_k;
            if (w_seq_viol) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    buf2_fifo #(
        .WIDTH (BUF_W)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_in_valid),
        .o_ready (w_in_ready),
        .i_data  ({w_sigma, w_k}),
        .o_valid (o_out_valid),
        .i_ready (i_out_ready),
        .o_data  (w_buf_out)
    );

    assign o_in_ready  = w_in_ready;
    assign o_out_data  = w_buf_out[BUF_W-1:ROUND_W];
    assign o_out_round = w_buf_out[ROUND_W-1:0];
    assign o_out_last  = (w_buf_out[ROUND_W-1:0] == LAST_ROUND);
    assign o_seq_err   = r_seq_err;

endmodule : pi_sigma_stage
`default_nettype wire

// File: tb/tb_pi_sigma_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pi_sigma_stage
//  Description : Self-checking bench for pi_sigma_stage with a transaction
//                level reference model (key table, round rule, output queue).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_sigma_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_key_we = 1'b0;
    logic [3:0]   i_key_addr = '0;
    logic [127:0] i_key_wdata = '0;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [127:0] i_in_data = '0;
    logic         i_in_first = 1'b0;
    logic         o_out_valid;
    logic         i_out_ready = 1'b0;
    logic [127:0] o_out_data;
    logic [3:0]   o_out_round;
    logic         o_out_last;
    logic         o_seq_err;

    always #5 clk = ~clk;

    pi_sigma_stage #(
        .NUM_ROUNDS (8),
        .STATE_W    (128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_key_we    (i_key_we),
        .i_key_addr  (i_key_addr),
        .i_key_wdata (i_key_wdata),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_first  (i_in_first),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_round (o_out_round),
        .o_out_last  (o_out_last),
        .o_seq_err   (o_seq_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [127:0] m_key [9];
    int           m_r;
    bit           m_err;
    logic [131:0] m_q [$];

    // Observed (DUT) and expected (model) values for the current cycle
    logic         obs_rdy, obs_vld, obs_last, obs_err;
    logic [127:0] obs_data;
    logic [3:0]   obs_round;
    logic         exp_rdy, exp_vld, exp_last, exp_err;
    logic [127:0] exp_data;
    logic [3:0]   exp_round;
    bit           last_acc;

    function automatic logic [127:0] ref_pi(input logic [127:0] d);
        logic [7:0]   b [16];
        logic [127:0] o;
        for (int n = 0; n < 16; n++) b[n] = d[127-8*n -: 8];
        o = '0;
        // output position (row n/4, col n%4) takes input (row n%4, col n/4)
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = b[(n % 4) * 4 + (n / 4)];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int s = 0; s < 9; s++) m_key[s] = '0;
        m_r   = 0;
        m_err = 0;
    endtask

    // One clock cycle: drive inputs, capture DUT outputs and model
    // expectations for this cycle, advance the model, then clock.
    task automatic tick(input bit v, input bit f, input logic [127:0] d,
                        input bit ordy, input bit kwe, input logic [3:0] ka,
                        input logic [127:0] kd);
        int k;
        i_in_valid  = v;
        i_in_first  = f;
        i_in_data   = d;
        i_out_ready = ordy;
        i_key_we    = kwe;
        i_key_addr  = ka;
        i_key_wdata = kd;
        #1;
        obs_rdy   = o_in_ready;
        obs_vld   = o_out_valid;
        obs_data  = o_out_data;
        obs_round = o_out_round;
        obs_last  = o_out_last;
        obs_err   = o_seq_err;
        exp_vld   = (m_q.size() != 0);
        exp_rdy   = (m_q.size() < 2);
        exp_err   = m_err;
        exp_data  = '0;
        exp_round = '0;
        exp_last  = 1'b0;
        if (exp_vld) begin
            exp_data  = m_q[0][131:4];
            exp_round = m_q[0][3:0];
            exp_last  = (m_q[0][3:0] == 4'd8);
        end
        last_acc = v && exp_rdy;
        if (exp_vld && ordy) void'(m_q.pop_front());
        if (last_acc) begin
            if (f) k = 1;
            else if (m_r >= 1 && m_r <= 7) k = m_r + 1;
            else begin
                k = 1;
                m_err = 1;
            end
            m_r = k;
            m_q.push_back({ref_pi(d) ^ m_key[k], 4'(k)});
        end
        if (kwe && ka <= 4'd8) m_key[ka] = kd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", o_out_valid); end
        n_cmp++; if (o_out_data !== 128'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", o_out_data); end
        n_cmp++; if (o_out_round !== 4'd0 || o_out_last !== 1'b0) begin n_bad++; $display("FAIL reset_round: got %0d/%0b want 0/0", o_out_round, o_out_last); end
        n_cmp++; if (o_seq_err !== 1'b0) begin n_bad++; $display("FAIL reset_seq_err: got %0b want 0", o_seq_err); end
        n_cmp++; if (o_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_held: got %0b want 0", o_in_ready); end
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (o_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_after: got %0b want 1", o_in_ready); end
    endtask

    task automatic test_vectors();
        logic [127:0] vin;
        vin = 128'h000102030405060708090a0b0c0d0e0f;
        tick(0, 0, '0, 1, 1, 4'd1, '0);
        tick(1, 1, vin, 1, 0, 4'd0, '0);
        tick(0, 0, '0, 1, 0, 4'd0, '0);
        n_cmp++; if (obs_vld !== 1'b1) begin n_bad++; $display("FAIL vec0_valid: got %0b want 1", obs_vld); end
        n_cmp++; if (obs_data !== 128'h0004080c0105090d02060a0e03070b0f) begin n_bad++; $display("FAIL vec0_data: got %h want 0004080c0105090d02060a0e03070b0f", obs_data); end
        n_cmp++; if (obs_round !== 4'd1 || obs_last !== 1'b0) begin n_bad++; $display("FAIL vec0_round: got %0d/%0b want 1/0", obs_round, obs_last); end
        tick(0, 0, '0, 1, 1, 4'd1, {16{8'hff}});
        tick(1, 1, vin, 1, 0, 4'd0, '0);
        tick(0, 0, '0, 1, 0, 4'd0, '0);
        n_cmp++; if (obs_vld !== 1'b1 || obs_data !== 128'hfffbf7f3fefaf6f2fdf9f5f1fcf8f4f0) begin n_bad++; $display("FAIL vec1_data: got %0b/%h want 1/fffbf7f3fefaf6f2fdf9f5f1fcf8f4f0", obs_vld, obs_data); end
    endtask

    task automatic test_back_to_back();
        for (int s = 1; s <= 8; s++) tick(0, 0, '0, 1, 1, 4'(s), rnd128());
        for (int t = 0; t <= 8; t++) begin
            tick(t < 8, t == 0, rnd128(), 1, 0, 4'd0, '0);
            n_cmp++; if (obs_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready t%0d: got %0b want 1", t, obs_rdy); end
            if (t >= 1) begin
                n_cmp++; if (obs_vld !== 1'b1 || obs_round !== 4'(t) || obs_last !== (t == 8)) begin
                    n_bad++; $display("FAIL b2b_round t%0d: got v%0b r%0d l%0b want v1 r%0d l%0b", t, obs_vld, obs_round, obs_last, t, t == 8);
                end
                n_cmp++; if (obs_data !== exp_data) begin n_bad++; $display("FAIL b2b_data t%0d: got %h want %h", t, obs_data, exp_data); end
            end
        end
        n_cmp++; if (o_seq_err !== 1'b0) begin n_bad++; $display("FAIL b2b_seq_err: got %0b want 0", o_seq_err); end
    endtask

    task automatic test_hold();
        logic [127:0] d3;
        int           seen [$];
        bit           pending;
        d3 = rnd128();
        for (int t = 0; t < 3; t++) begin
            tick(1, t == 0, (t == 2) ? d3 : rnd128(), 0, 0, 4'd0, '0);
            n_cmp++; if (obs_rdy !== (t < 2)) begin n_bad++; $display("FAIL hold_ready t%0d: got %0b want %0b", t, obs_rdy, t < 2); end
        end
        pending = 1;
        for (int t = 0; t < 6; t++) begin
            tick(pending, 0, d3, 1, 0, 4'd0, '0);
            if (last_acc) pending = 0;
            n_cmp++; if (obs_vld !== exp_vld) begin n_bad++; $display("FAIL hold_valid t%0d: got %0b want %0b", t, obs_vld, exp_vld); end
            if (exp_vld) begin
                seen.push_back(int'(obs_round));
                n_cmp++; if (obs_data !== exp_data || obs_round !== exp_round) begin n_bad++; $display("FAIL hold_data t%0d: got %h/%0d want %h/%0d", t, obs_data, obs_round, exp_data, exp_round); end
            end
        end
        n_cmp++; if (seen.size() != 3 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3) begin n_bad++; $display("FAIL hold_order: got %0d beats want rounds 1,2,3", seen.size()); end
    endtask

    task automatic test_seq_and_collision();
        for (int t = 0; t < 8; t++) tick(1, t == 0, rnd128(), 1, 0, 4'd0, '0);
        tick(1, 0, rnd128(), 1, 0, 4'd0, '0);
        tick(0, 0, '0, 1, 0, 4'd0, '0);
        n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL seq_err_set: got %0b want 1", obs_err); end
        n_cmp++; if (obs_vld !== 1'b1 || obs_round !== 4'd1) begin n_bad++; $display("FAIL seq_err_round: got v%0b r%0d want v1 r1", obs_vld, obs_round); end
        // round-2 beat with a same-cycle write to key[2]: old key applies
        tick(1, 1, rnd128(), 1, 0, 4'd0, '0);
        tick(1, 0, rnd128(), 1, 1, 4'd2, rnd128());
        tick(1, 1, rnd128(), 1, 0, 4'd0, '0);
        n_cmp++; if (obs_data !== exp_data || obs_round !== 4'd2) begin n_bad++; $display("FAIL key_collision_old: got %h/%0d want %h/2", obs_data, obs_round, exp_data); end
        tick(1, 0, rnd128(), 1, 0, 4'd0, '0);
        tick(0, 0, '0, 1, 0, 4'd0, '0);
        n_cmp++; if (obs_data !== exp_data || obs_round !== 4'd2) begin n_bad++; $display("FAIL key_collision_new: got %h/%0d want %h/2", obs_data, obs_round, exp_data); end
        n_cmp++; if (obs_err !== 1'b1) begin n_bad++; $display("FAIL seq_err_sticky: got %0b want 1", obs_err); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rnd128(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 15)), rnd128());
            n_cmp++; if (obs_vld !== exp_vld || obs_rdy !== exp_rdy || obs_err !== exp_err) begin
                n_bad++; $display("FAIL rand_ctrl t%0d: got v%0b r%0b e%0b want v%0b r%0b e%0b", t, obs_vld, obs_rdy, obs_err, exp_vld, exp_rdy, exp_err);
            end
            if (exp_vld) begin
                n_cmp++; if (obs_data !== exp_data || obs_round !== exp_round || obs_last !== exp_last) begin
                    n_bad++; $display("FAIL rand_beat t%0d: got %h/%0d/%0b want %h/%0d/%0b", t, obs_data, obs_round, obs_last, exp_data, exp_round, exp_last);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [127:0] d;
        for (int s = 1; s <= 8; s++) tick(0, 0, '0, 1, 1, 4'(s), rnd128());
        for (int t = 0; t < 5; t++) tick(1, t == 0, rnd128(), t < 4, 0, 4'd0, '0);
        tick(0, 0, '0, 0, 0, 4'd0, '0);
        n_cmp++; if (obs_rdy !== 1'b0 || obs_vld !== 1'b1 || obs_round !== 4'd4) begin n_bad++; $display("FAIL midrst_full: got r%0b v%0b rnd%0d want r0 v1 rnd4", obs_rdy, obs_vld, obs_round); end
        rst = 1'b1;
        #1;
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %0b want 0", o_out_valid); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_seq_err !== 1'b0) begin n_bad++; $display("FAIL midrst_release: got r%0b v%0b e%0b want r1 v0 e0", o_in_ready, o_out_valid, o_seq_err); end
        d = rnd128();
        tick(1, 1, d, 1, 0, 4'd0, '0);
        tick(1, 0, rnd128(), 1, 0, 4'd0, '0);
        n_cmp++; if (obs_vld !== 1'b1 || obs_data !== ref_pi(d) || obs_round !== 4'd1) begin n_bad++; $display("FAIL midrst_zero_key: got v%0b %h/%0d want v1 %h/1", obs_vld, obs_data, obs_round, ref_pi(d)); end
        tick(0, 0, '0, 1, 0, 4'd0, '0);
        n_cmp++; if (obs_data !== exp_data || obs_round !== 4'd2) begin n_bad++; $display("FAIL midrst_round2: got %h/%0d want %h/2", obs_data, obs_round, exp_data); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_vectors();
        test_back_to_back();
        test_hold();
        test_seq_and_collision();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pi_sigma_stage
`default_nettype wire
